// File: rtl/debug_cmd_sequencer_pkg.sv
// debug_pkg: shared types for the debug command sequencer.
//   cmd_t       - command codes coming from the serial front end
//   seq_state_t - sequencer FSM states
//   strobe_t    - the MCU debug-port strobe bundle, in output order
//   cmd_strobes - strobe pattern raised during the ISSUE cycle of a command
package debug_pkg;

  localparam int DEBUG_TIMEOUT_DEFAULT = 1024;
  localparam int CMD_W                 = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP      = 4'd0,
    CMD_PAUSE    = 4'd1,
    CMD_RESUME   = 4'd2,
    CMD_RESET    = 4'd3,
    CMD_STATUS   = 4'd4,
    CMD_REG_RD   = 4'd5,
    CMD_REG_WR   = 4'd6,
    CMD_MEM_RD_W = 4'd7,
    CMD_MEM_WR_W = 4'd8,
    CMD_MEM_RD_B = 4'd9,
    CMD_MEM_WR_B = 4'd10
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  typedef struct packed {
    logic pause;
    logic resume;
    logic mcu_reset;
    logic reg_rd;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic mem_rw_byte;
    logic valid;
  } strobe_t;

  // All-zero result means the command never touches the MCU.
  function automatic strobe_t cmd_strobes(input cmd_t c);
    strobe_t s;
    s       = '0;
    s.valid = 1'b1;
    case (c)
      CMD_PAUSE:    s.pause     = 1'b1;
      CMD_RESUME:   s.resume    = 1'b1;
      CMD_RESET:    s.mcu_reset = 1'b1;
      CMD_REG_RD:   s.reg_rd    = 1'b1;
      CMD_REG_WR:   s.reg_wr    = 1'b1;
      CMD_MEM_RD_W: s.mem_rd    = 1'b1;
      CMD_MEM_WR_W: s.mem_wr    = 1'b1;
      CMD_MEM_RD_B: begin s.mem_rd = 1'b1; s.mem_rw_byte = 1'b1; end
      CMD_MEM_WR_B: begin s.mem_wr = 1'b1; s.mem_rw_byte = 1'b1; end
      default:      s = '0;
    endcase
    return s;
  endfunction

  function automatic logic needs_pause(input cmd_t c);
    return c inside {CMD_REG_RD, CMD_REG_WR, CMD_MEM_RD_W, CMD_MEM_WR_W,
                     CMD_MEM_RD_B, CMD_MEM_WR_B};
  endfunction

  function automatic logic is_read(input cmd_t c);
    return c inside {CMD_REG_RD, CMD_MEM_RD_W, CMD_MEM_RD_B};
  endfunction

endpackage

// File: rtl/debug_cmd_sequencer_if.sv
// debug_cmd_sequencer_if: command side (serial driver) and MCU debug port of
// the sequencer, bundled together.
//   master - the sequencer: takes commands and MCU status, drives strobes,
//            latched address/data, response and paused flag
//   slave  - the environment (serial driver + MCU)
interface debug_cmd_sequencer_if;
  import debug_pkg::*;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_data;
  logic             ctrlr_busy;

  logic [31:0]      pc;
  logic             mcu_busy;
  logic [31:0]      d_rd;
  logic             error;

  logic [31:0]      addr;
  logic [31:0]      d_in;
  logic             pause, resume, mcu_reset, reg_rd, reg_wr;
  logic             mem_rd, mem_wr, mem_rw_byte, valid;

  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             paused;

  modport master (
    input  cmd_valid, cmd, cmd_addr, cmd_data, pc, mcu_busy, d_rd, error,
    output ctrlr_busy, addr, d_in, pause, resume, mcu_reset, reg_rd, reg_wr,
           mem_rd, mem_wr, mem_rw_byte, valid, rsp_valid, rsp_data, rsp_err, paused
  );

  modport slave (
    output cmd_valid, cmd, cmd_addr, cmd_data, pc, mcu_busy, d_rd, error,
    input  ctrlr_busy, addr, d_in, pause, resume, mcu_reset, reg_rd, reg_wr,
           mem_rd, mem_wr, mem_rw_byte, valid, rsp_valid, rsp_data, rsp_err, paused
  );
endinterface

// File: rtl/debug_cmd_sequencer_wait_timer.sv
// wait_timer: counts cycles spent waiting on the MCU.
//   clk, reset - clock, asynchronous active-high reset
//   clr        - return count to zero (has priority over en)
//   en         - advance count by one
//   first      - count is zero (first cycle after a clear)
//   tc         - count has reached TIMEOUT-1, i.e. this is the TIMEOUT-th cycle
// TIMEOUT must be at least 2 so that tc never coincides with first.
module wait_timer
  import debug_pkg::*;
#(
  parameter int TIMEOUT = DEBUG_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign first = (cnt_q == '0);
  assign tc    = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: turns decoded debugger commands into single MCU
// debug-port operations and returns exactly one response per command.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - debug_cmd_sequencer_if.master: command input, busy flag,
//                MCU strobes/status, latched addr/d_in, response, paused
// Every output is a flop (or a decode of the state flop); strobes are high
// only in the single ISSUE cycle.
module debug_cmd_sequencer
  import debug_pkg::*;
#(
  parameter int TIMEOUT = DEBUG_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  debug_cmd_sequencer_if.master bus
);

  seq_state_t  state_q, state_d;
  cmd_t        cmd_q, cmd_in;
  strobe_t     stb_q, stb_d, stb_in;
  logic [31:0] addr_q, d_in_q;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        paused_q, paused_d;
  logic        accept;
  logic        tmr_first, tmr_tc;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_WAIT),
    .en    (state_q == ST_WAIT),
    .first (tmr_first),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    cmd_in      = cmd_t'(bus.cmd);
    stb_in      = cmd_strobes(cmd_in);
    state_d     = state_q;
    stb_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    paused_d    = paused_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (stb_in.valid && (paused_q || !needs_pause(cmd_in))) begin
            state_d = ST_ISSUE;
            stb_d   = stb_in;
          end else begin
            // NOP, STATUS, access while running, or unknown code
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !(cmd_in inside {CMD_NOP, CMD_STATUS});
            rsp_data_d  = (cmd_in == CMD_STATUS) ? {31'b0, paused_q} : '0;
          end
        end
      end
      ST_ISSUE: begin
        // RESUME has nothing to wait for
        if (cmd_q == CMD_RESUME) begin
          paused_d    = 1'b0;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // first WAIT cycle is a grace cycle: mcu_busy may still be stale
        if (!tmr_first && !bus.mcu_busy) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.error;
          if (is_read(cmd_q))          rsp_data_d = bus.d_rd;
          else if (cmd_q == CMD_PAUSE) rsp_data_d = bus.pc;
          if (!bus.error) begin
            if (cmd_q == CMD_PAUSE) paused_d = 1'b1;
            if (cmd_q == CMD_RESET) paused_d = 1'b0;
          end
        end else if (tmr_tc) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      d_in_q      <= '0;
      stb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      stb_q       <= stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      paused_q    <= paused_d;
      if (accept) begin
        cmd_q  <= cmd_in;
        addr_q <= bus.cmd_addr;
        d_in_q <= bus.cmd_data;
      end
    end
  end

  assign bus.ctrlr_busy  = (state_q != ST_IDLE);
  assign bus.addr        = addr_q;
  assign bus.d_in        = d_in_q;
  assign bus.pause       = stb_q.pause;
  assign bus.resume      = stb_q.resume;
  assign bus.mcu_reset   = stb_q.mcu_reset;
  assign bus.reg_rd      = stb_q.reg_rd;
  assign bus.reg_wr      = stb_q.reg_wr;
  assign bus.mem_rd      = stb_q.mem_rd;
  assign bus.mem_wr      = stb_q.mem_wr;
  assign bus.mem_rw_byte = stb_q.mem_rw_byte;
  assign bus.valid       = stb_q.valid;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.paused      = paused_q;

endmodule

// File: doc/debug_cmd_sequencer.md
# debug_cmd_sequencer

Sequences decoded debugger commands from the serial front end into single-operation handshakes on the target MCU's debug port, and returns one response per command. Sits between the serial driver and the MCU. Tracks the MCU paused state and enforces that register and memory accesses only occur while the MCU is paused. Bounds every MCU wait with a timeout.

## Interface
- `TIMEOUT`, 1024: maximum WAIT cycles before an operation is aborted with an error; must be ≥ 2.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present; sampled only in IDLE
- `cmd`  in  4  command code (`cmd_t`)
- `cmd_addr`  in  32  register index / memory address
- `cmd_data`  in  32  write data
- `ctrlr_busy`  out  1  high whenever state ≠ IDLE
- `pc`  in  32  MCU program counter
- `mcu_busy`  in  1  MCU is executing or servicing an operation
- `d_rd`  in  32  MCU read data
- `error`  in  1  MCU reports a failed access
- `addr`, `d_in`  out  32 each  latched `cmd_addr` / `cmd_data`
- `pause`, `resume`, `mcu_reset`, `reg_rd`, `reg_wr`, `mem_rd`, `mem_wr`, `mem_rw_byte`, `valid`  out  1 each  MCU strobes
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_data`  out  32  response payload
- `rsp_err`  out  1  response is an error
- `paused`  out  1  MCU is known to be paused

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE. Commands that need no MCU access go IDLE → RESP.
- Accept: when `cmd_valid` is high in IDLE, latch `cmd`, `addr`, and `d_in`.
  - `cmd_valid` outside IDLE is ignored and the command is dropped.
  - The serial driver must not assert `cmd_valid` while `ctrlr_busy` is high.
- Command codes:
  - 0 NOP: → RESP with data 0.
  - 1 PAUSE: ISSUE pulses `pause`; on completion set `paused`=1; data = `pc`.
  - 2 RESUME: pulse `resume` in ISSUE, clear `paused`, go directly to RESP with data 0; there is no WAIT.
  - 3 RESET: pulse `mcu_reset`; on completion clear `paused`; data 0.
  - 4 STATUS: → RESP with data = {31'b0, `paused`}.
  - 5 REG_RD, 6 REG_WR, 7 MEM_RD_W, 8 MEM_WR_W, 9 MEM_RD_B, 10 MEM_WR_B: each requires `paused`=1.
    - If not paused: → RESP with `rsp_err`=1 and data 0, and nothing is issued.
    - Read commands return `d_rd` captured in the completion cycle; writes return 0.
    - The `_B` variants also assert `mem_rw_byte`.
  - 11–15: → RESP with `rsp_err`=1 and data 0.
- ISSUE lasts exactly one cycle. In it, `valid` and the command's strobe(s) are high; all other strobes stay 0.
- WAIT:
  - The first WAIT cycle is a grace cycle, and `mcu_busy` is ignored.
  - Completion is the first later cycle with `mcu_busy`=0. In that cycle, capture `d_rd` and `error` (error → `rsp_err`).
  - The timeout counter counts WAIT cycles. On reaching `TIMEOUT` with `mcu_busy` still high → RESP, `rsp_err`=1, data 0, and `paused` is unchanged.
- RESP: `rsp_valid`=1 for one cycle, `rsp_data`/`rsp_err` valid in the same cycle, then → IDLE. There is no response backpressure.
- `paused` changes only on successful PAUSE completion, on RESUME, or on successful RESET completion.

## Timing
- Reset (asynchronous, immediate): state IDLE; every output 0, including `paused`, `addr`, `d_in`, `rsp_*`, strobes, and counter.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Accept at edge T:
  - ISSUE is T+1 and the first WAIT (grace) cycle is T+2.
  - Earliest completion is T+3, so `rsp_valid` is at T+4. Minimum MCU-op latency: 4 cycles from accept to response.
- Non-MCU commands (NOP, STATUS, rejected, illegal): `rsp_valid` at T+1.
- RESUME: `resume` at T+1, `rsp_valid` at T+2.
- Next accept is possible in the cycle after RESP; back-to-back throughput is one command per 5 cycles for MCU ops.
- `addr`/`d_in` hold from accept until the next accept.
- Reset asserted mid-operation: the operation is aborted and no response is emitted.

## Structure
- Package `debug_pkg`: `cmd_t` enum (codes above), `seq_state_t` enum, and a `DEBUG_TIMEOUT_DEFAULT` constant.
- One sub-module, `wait_timer`: a cycle counter with clear/enable and a terminal-count flag, parameterised by `TIMEOUT`.
- The FSM and datapath latches stay in `debug_cmd_sequencer`.

## Test plan
- Reset, then MEM_RD_W addr 0x100 while not paused → response at T+1 with `rsp_err`=1; no strobe ever asserted.
- PAUSE with `mcu_busy` high for 5 cycles, `pc`=0x0000_0040 → single `pause` pulse; `rsp_data`=0x40, `paused`=1.
- Paused, MEM_WR_B addr 0x2003 data 0xAB → one ISSUE cycle with `mem_wr`=`mem_rw_byte`=`valid`=1 and `addr`=0x2003; `mcu_busy` low → `rsp_valid` at T+4 with data 0.
- Paused, REG_RD addr 5, `d_rd`=0xDEAD_BEEF with `error`=1 in the completion cycle → `rsp_data`=0xDEADBEEF, `rsp_err`=1.
- `TIMEOUT`=8, REG_WR with `mcu_busy` stuck high → RESP after 8 WAIT cycles with `rsp_err`=1; `paused` stays 1.
- Assert `reset` during WAIT → all outputs 0 immediately, no `rsp_valid`; `cmd_valid` during busy is dropped (no second response).
